// File: rtl/gvp_pack_pkg.sv
// gvp_pack_pkg
//   Shared definitions for the GVP stream packer: store codes, frame tags,
//   frame size limit, the queued frame entry type and a tag lookup helper.
//   Build option: GVP_PACK_TIME_EN (consumed by gvp_stream_packer) adds the
//   time lo/hi words to data frames.
package gvp_pack_pkg;

  typedef enum logic [1:0] {
    STORE_NONE = 2'd0,
    STORE_DATA = 2'd1,
    STORE_HDR  = 2'd2,
    STORE_END  = 2'd3
  } store_e;

  localparam logic [3:0] TAG_HDR  = 4'h1;
  localparam logic [3:0] TAG_DATA = 4'h2;
  localparam logic [3:0] TAG_END  = 4'hF;

  localparam int MAX_FRAME_WORDS = 8;

  // One queued frame: up to eight words, a word count of 1..8 and a flag
  // marking the end-mark frame (drives tlast on its final word).
  typedef struct packed {
    logic [MAX_FRAME_WORDS-1:0][31:0] words;
    logic [3:0]                       count;
    logic                             last;
  } frame_t;

  function automatic logic [3:0] store_tag(input logic [1:0] code);
    case (code)
      STORE_HDR: store_tag = TAG_HDR;
      STORE_END: store_tag = TAG_END;
      default:   store_tag = TAG_DATA;
    endcase
  endfunction

endpackage

// File: rtl/gvp_frame_fifo.sv
// gvp_frame_fifo
//   Single-clock FIFO of whole frame entries with a show-ahead head.
//   Ports:
//     a_clk, a_resetn   clock, asynchronous active-low reset
//     wr_en, wr_data    push a frame (accepted when not full, or when a
//                       release happens in the same cycle)
//     rd_en             release the head entry
//     head, head_next   oldest entry and the one behind it
//     full, empty       occupancy == depth / occupancy == 0
//     almost_full       occupancy >= depth-1
//     occupancy         number of stored entries (0..depth)
module gvp_frame_fifo
  import gvp_pack_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic        a_clk,
  input  logic        a_resetn,
  input  logic        wr_en,
  input  frame_t      wr_data,
  input  logic        rd_en,
  output frame_t      head,
  output frame_t      head_next,
  output logic        full,
  output logic        empty,
  output logic        almost_full,
  output logic [AW:0] occupancy
);

  localparam int DEPTH = 2**AW;

  frame_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic          do_wr;
  logic          do_rd;

  assign rd_ptr_nxt = rd_ptr + AW'(1);
  assign do_rd      = rd_en && !empty;
  // When full, a write in the same cycle as a release reuses the freed slot.
  assign do_wr      = wr_en && (!full || do_rd);

  assign full        = (occupancy == (AW+1)'(DEPTH));
  assign empty       = (occupancy == '0);
  assign almost_full = (occupancy >= (AW+1)'(DEPTH - 1));
  assign head        = mem[rd_ptr];
  assign head_next   = mem[rd_ptr_nxt];

  always_ff @(posedge a_clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr_nxt;
      end
      occupancy <= occupancy + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end

endmodule

// File: rtl/gvp_stream_packer.sv
// gvp_stream_packer
//   Captures GVP store events (header, data point, end mark) into tagged
//   frames, queues whole frames and streams them as 32-bit AXI-Stream words.
//   Build option: GVP_PACK_TIME_EN -- data frames carry time lo/hi words.
//   Ports:
//     a_clk, a_resetn        clock, asynchronous active-low reset
//     store_data             0 none, 1 data, 2 header, 3 end mark
//     options                [15:0] into tag word, [NUM_CH-1:0] channel mask
//     index, gvp_time        point index, 48-bit run time
//     ch_x/ch_y/ch_z/ch_u    channel values (ascending mask bit order)
//     M_AXIS_*               registered AXI-Stream master
//     stall                  registered, high when at most one slot is free
//     overflow_count         dropped frames, saturating
//     frame_seq              sequence number of the next captured frame
//
//   Serialiser states
//     state   | meaning
//     ST_IDLE | no frame on the output, waiting for a queued frame
//     ST_SEND | presenting word[ptr] of the head frame
module gvp_stream_packer
  import gvp_pack_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int NUM_CH  = 4
) (
  input  logic        a_clk,
  input  logic        a_resetn,
  input  logic [1:0]  store_data,
  input  logic [31:0] options,
  input  logic [31:0] index,
  input  logic [47:0] gvp_time,
  input  logic [31:0] ch_x,
  input  logic [31:0] ch_y,
  input  logic [31:0] ch_z,
  input  logic [31:0] ch_u,
  output logic [31:0] M_AXIS_tdata,
  output logic        M_AXIS_tvalid,
  input  logic        M_AXIS_tready,
  output logic        M_AXIS_tlast,
  output logic        stall,
  output logic [15:0] overflow_count,
  output logic [11:0] frame_seq
);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  logic [1:0]       prev_store;
  logic [31:0]      prev_index;
  logic             trigger;
  logic             accept;
  logic [3:0][31:0] ch_vec;
  frame_t           cap;
  logic [3:0]       n;
  logic             unused_opts;

  frame_t           head;
  frame_t           head_next;
  frame_t           src;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_afull;
  logic [FIFO_AW:0] fifo_occ;

  state_e           state;
  logic [3:0]       ptr;
  logic [3:0]       ptr_nxt;
  logic [3:0]       cur_count;
  logic             cur_last;
  logic             fire;
  logic             word_last;
  logic             release_frame;
  logic             load_now;

  assign unused_opts = ^options[31:16];
  assign ch_vec      = {ch_u, ch_z, ch_y, ch_x};

  // Level-held store codes from the decimated GVP only count once per
  // change of code or index.
  assign trigger = (store_data != STORE_NONE) &&
                   ((store_data != prev_store) || (index != prev_index));

  always_comb begin
    cap          = '0;
    cap.words[0] = {store_tag(store_data), frame_seq, options[15:0]};
    n            = 4'd1;
    if (store_data == STORE_HDR || store_data == STORE_END) begin
      cap.words[1] = index;
      cap.words[2] = gvp_time[31:0];
      cap.words[3] = {16'h0, gvp_time[47:32]};
      n            = 4'd4;
    end
`ifdef GVP_PACK_TIME_EN
    else begin
      cap.words[1] = gvp_time[31:0];
      cap.words[2] = {16'h0, gvp_time[47:32]};
      n            = 4'd3;
    end
`endif
    if (store_data != STORE_END) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (options[c]) begin
          cap.words[n[2:0]] = ch_vec[c];
          n                 = n + 4'd1;
        end
      end
    end
    cap.count = n;
    cap.last  = (store_data == STORE_END);
  end

  // The head entry stays in the FIFO until its last word is accepted, so the
  // frame on the wire still occupies a slot for full/stall purposes.
  assign fire          = M_AXIS_tvalid && M_AXIS_tready;
  assign ptr_nxt       = ptr + 4'd1;
  assign word_last     = (ptr_nxt == cur_count);
  assign release_frame = (state == ST_SEND) && fire && word_last;
  assign load_now      = ((state == ST_IDLE) && !fifo_empty) ||
                         (release_frame && (fifo_occ >= (FIFO_AW+1)'(2)));
  assign src           = (state == ST_SEND && word_last) ? head_next : head;
  assign accept        = trigger && (!fifo_full || release_frame);

  gvp_frame_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .a_clk       (a_clk),
    .a_resetn    (a_resetn),
    .wr_en       (accept),
    .wr_data     (cap),
    .rd_en       (release_frame),
    .head        (head),
    .head_next   (head_next),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (fifo_afull),
    .occupancy   (fifo_occ)
  );

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      prev_store     <= 2'd0;
      prev_index     <= 32'd0;
      frame_seq      <= 12'd0;
      overflow_count <= 16'd0;
      stall          <= 1'b0;
    end else begin
      prev_store <= store_data;
      prev_index <= index;
      stall      <= fifo_afull;
      if (trigger) begin
        if (accept) begin
          frame_seq <= frame_seq + 12'd1;
        end else if (overflow_count != 16'hFFFF) begin
          overflow_count <= overflow_count + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state         <= ST_IDLE;
      ptr           <= 4'd0;
      cur_count     <= 4'd0;
      cur_last      <= 1'b0;
      M_AXIS_tdata  <= 32'd0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tlast  <= 1'b0;
    end else begin
      if (load_now) begin
        state         <= ST_SEND;
        ptr           <= 4'd0;
        cur_count     <= src.count;
        cur_last      <= src.last;
        M_AXIS_tdata  <= src.words[0];
        M_AXIS_tvalid <= 1'b1;
        M_AXIS_tlast  <= src.last && (src.count == 4'd1);
      end else if (state == ST_SEND && fire) begin
        if (word_last) begin
          state         <= ST_IDLE;
          M_AXIS_tvalid <= 1'b0;
          M_AXIS_tlast  <= 1'b0;
        end else begin
          ptr          <= ptr_nxt;
          M_AXIS_tdata <= src.words[ptr_nxt[2:0]];
          M_AXIS_tlast <= cur_last && ((ptr_nxt + 4'd1) == cur_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_gvp_stream_packer.sv
module tb_gvp_stream_packer;

  localparam int FIFO_AW = 2;
  localparam int NUM_CH  = 4;
`ifdef GVP_PACK_TIME_EN
  localparam bit TIME_EN = 1'b1;
`else
  localparam bit TIME_EN = 1'b0;
`endif
  localparam int DSTRIDE = TIME_EN ? 4 : 2;

  logic        a_clk = 1'b0;
  logic        a_resetn = 1'b0;
  logic [1:0]  store_data = 2'd0;
  logic [31:0] options = 32'd0;
  logic [31:0] index = 32'd0;
  logic [47:0] gvp_time = 48'd0;
  logic [31:0] ch_x = 32'd0, ch_y = 32'd0, ch_z = 32'd0, ch_u = 32'd0;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready = 1'b1;
  logic        M_AXIS_tlast;
  logic        stall;
  logic [15:0] overflow_count;
  logic [11:0] frame_seq;

  gvp_stream_packer #(.FIFO_AW(FIFO_AW), .NUM_CH(NUM_CH)) dut (
    .a_clk(a_clk), .a_resetn(a_resetn), .store_data(store_data),
    .options(options), .index(index), .gvp_time(gvp_time),
    .ch_x(ch_x), .ch_y(ch_y), .ch_z(ch_z), .ch_u(ch_u),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tlast(M_AXIS_tlast),
    .stall(stall), .overflow_count(overflow_count), .frame_seq(frame_seq)
  );

  always #5 a_clk = ~a_clk;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;   // 0 hold, 1 toggle, 2 random
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  logic [31:0] got_q[$];
  logic        got_last_q[$];
  logic [1:0]  m_prev_store = 2'd0;
  logic [31:0] m_prev_index = 32'd0;
  int          m_seq = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic l);
    exp_q.push_back(w);
    exp_last_q.push_back(l);
  endtask

  // Reference frame built straight from the frame layout rules.
  task automatic model_frame(input logic [1:0] st);
    logic [31:0] chv [4];
    logic [3:0]  tg;
    chv = '{ch_x, ch_y, ch_z, ch_u};
    tg = (st == 2'd2) ? 4'h1 : (st == 2'd1) ? 4'h2 : 4'hF;
    push({tg, 12'(m_seq), options[15:0]}, 1'b0);
    if (st != 2'd1) begin
      push(index, 1'b0);
      push(gvp_time[31:0], 1'b0);
      push({16'h0, gvp_time[47:32]}, st == 2'd3);
    end else if (TIME_EN) begin
      push(gvp_time[31:0], 1'b0);
      push({16'h0, gvp_time[47:32]}, 1'b0);
    end
    if (st != 2'd3)
      for (int c = 0; c < NUM_CH; c++)
        if (options[c]) push(chv[c], 1'b0);
  endtask

  // Advance one cycle with the inputs currently applied.
  task automatic tick(input bit drop);
    case (rdy_mode)
      1: M_AXIS_tready = ~M_AXIS_tready;
      2: M_AXIS_tready = 1'($urandom_range(0, 1));
      default: ;
    endcase
    if (store_data != 2'd0 && (store_data != m_prev_store || index != m_prev_index)) begin
      if (!drop) begin
        model_frame(store_data);
        m_seq = (m_seq + 1) % 4096;
      end
    end
    m_prev_store = store_data;
    m_prev_index = index;
    @(posedge a_clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int w = 0; w < 400 && (exp_q.size() != 0 || M_AXIS_tvalid); w++) tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    chk(tag, exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard against the model and AXI hold rules.
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = 32'd0;
  always @(negedge a_clk) begin
    if (!a_resetn) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", M_AXIS_tvalid, 1);
        chk("hold_data", M_AXIS_tdata, pd);
        chk("hold_last", M_AXIS_tlast, pl);
      end
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        got_q.push_back(M_AXIS_tdata);
        got_last_q.push_back(M_AXIS_tlast);
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("tdata", M_AXIS_tdata, exp_q.pop_front());
          chk("tlast", M_AXIS_tlast, exp_last_q.pop_front());
        end
      end
      pv = M_AXIS_tvalid;
      pr = M_AXIS_tready;
      pd = M_AXIS_tdata;
      pl = M_AXIS_tlast;
    end
  end

  initial begin
    int seq0;
    // reset state
    #1;
    chk("rst_tdata", M_AXIS_tdata, 0);
    chk("rst_tvalid", M_AXIS_tvalid, 0);
    chk("rst_tlast", M_AXIS_tlast, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ovf", overflow_count, 0);
    chk("rst_seq", frame_seq, 0);
    @(posedge a_clk);
    #1;
    a_resetn = 1'b1;

    // header, level-held for 5 cycles
    got_q.delete(); got_last_q.delete();
    options = 32'h0000_0005; index = 32'd10; gvp_time = 48'h0001_0000_0002;
    ch_x = 32'h11; ch_y = 32'h22; ch_z = 32'h33; ch_u = 32'h44;
    store_data = 2'd2;
    chk("hdr_first_word_tvalid_pre", M_AXIS_tvalid, 0);
    tick(1'b0);
    chk("hdr_latency_1", M_AXIS_tvalid, 0);
    tick(1'b0);
    chk("hdr_latency_2", M_AXIS_tvalid, 1);
    repeat (3) tick(1'b0);
    store_data = 2'd0;
    wait_drain("hdr_drain");
    chk("hdr_len", got_q.size(), 6);
    if (got_q.size() == 6) begin
      chk("hdr_w0", got_q[0], 32'h1000_0005);
      chk("hdr_w1", got_q[1], 32'd10);
      chk("hdr_w2", got_q[2], 32'd2);
      chk("hdr_w3", got_q[3], 32'd1);
      chk("hdr_w4", got_q[4], 32'h11);
      chk("hdr_w5", got_q[5], 32'h33);
      chk("hdr_nolast", {got_last_q[0], got_last_q[1], got_last_q[2], got_last_q[3], got_last_q[4], got_last_q[5]}, 0);
    end

    // data run with index held for two cycles per point
    got_q.delete(); got_last_q.delete();
    options = 32'h0000_0001; store_data = 2'd1;
    for (int i = 9; i >= 7; i--) begin
      index = 32'(i); ch_x = 32'h100 + 32'(i);
      tick(1'b0);
      tick(1'b0);
    end
    wait_drain("data_drain");
    chk("data_len", got_q.size(), 3 * DSTRIDE);
    if (got_q.size() == 3 * DSTRIDE)
      for (int k = 0; k < 3; k++) begin
        chk("data_tag", got_q[k*DSTRIDE], {4'h2, 12'(k + 1), 16'h0001});
        chk("data_x", got_q[k*DSTRIDE + DSTRIDE - 1], 32'h100 + 32'(9 - k));
      end

    // end mark
    got_q.delete(); got_last_q.delete();
    options = 32'h0000_00A5; gvp_time = 48'hABCD_1234_5678; index = 32'd0; store_data = 2'd3;
    tick(1'b0);
    store_data = 2'd0;
    wait_drain("end_drain");
    chk("end_len", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("end_tag", got_q[0], 32'hF004_00A5);
      chk("end_index", got_q[1], 32'd0);
      chk("end_tlo", got_q[2], 32'h1234_5678);
      chk("end_thi", got_q[3], 32'h0000_ABCD);
      chk("end_last", {got_last_q[0], got_last_q[1], got_last_q[2], got_last_q[3]}, 4'b0001);
    end
    chk("end_seq", frame_seq, 12'd5);

    // backpressure 1010 with full channel mask, paced by stall
    rdy_mode = 1;
    options = 32'h0000_000F; store_data = 2'd1;
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < 200 && stall; w++) tick(1'b0);
      index = 32'd20 + 32'(k);
      ch_x = $urandom; ch_y = $urandom; ch_z = $urandom; ch_u = $urandom;
      gvp_time = 48'({$urandom, $urandom});
      tick(1'b0);
    end
    wait_drain("bp_drain");

    // random stream against the model
    rdy_mode = 2;
    for (int i = 0; i < 80; i++) begin
      options = $urandom; index = 32'($urandom_range(0, 3));
      gvp_time = 48'({$urandom, $urandom});
      ch_x = $urandom; ch_y = $urandom; ch_z = $urandom; ch_u = $urandom;
      store_data = stall ? 2'd0 : 2'($urandom_range(0, 3));
      tick(1'b0);
    end
    store_data = 2'd0;
    wait_drain("rand_drain");
    chk("rand_ovf", overflow_count, 0);
    chk("rand_seq", frame_seq, 12'(m_seq));

    // overflow: consumer blocked, five triggers into four slots
    rdy_mode = 0; M_AXIS_tready = 1'b0;
    options = 32'h0000_0001; store_data = 2'd1;
    seq0 = m_seq;
    for (int k = 0; k < 5; k++) begin
      index = 32'd100 + 32'(k);
      tick(k == 4);
      if (k == 2) chk("ovf_stall_low", stall, 0);
      if (k == 3) chk("ovf_stall_high", stall, 1);
    end
    chk("ovf_count", overflow_count, 1);
    chk("ovf_seq", frame_seq, 12'((seq0 + 4) % 4096));
    chk("ovf_seq_model", frame_seq, 12'(m_seq));
    store_data = 2'd0;
    M_AXIS_tready = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_stall_clear", stall, 0);

    // mid-frame reset during word 2 of an 8-word header
    M_AXIS_tready = 1'b0;
    options = 32'h0000_000F; index = 32'd50; store_data = 2'd2;
    tick(1'b0);
    store_data = 2'd0;
    for (int w = 0; w < 10 && !M_AXIS_tvalid; w++) tick(1'b0);
    chk("mrst_valid", M_AXIS_tvalid, 1);
    M_AXIS_tready = 1'b1;
    tick(1'b0);
    tick(1'b0);
    M_AXIS_tready = 1'b0;
    chk("mrst_remaining", exp_q.size(), 6);
    #2;
    a_resetn = 1'b0;
    #1;
    chk("mrst_tdata", M_AXIS_tdata, 0);
    chk("mrst_tvalid", M_AXIS_tvalid, 0);
    chk("mrst_tlast", M_AXIS_tlast, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_ovf", overflow_count, 0);
    chk("mrst_seq", frame_seq, 0);
    exp_q.delete(); exp_last_q.delete();
    m_seq = 0; m_prev_store = 2'd0; m_prev_index = 32'd0;
    repeat (2) @(posedge a_clk);
    #1;
    a_resetn = 1'b1;
    got_q.delete(); got_last_q.delete();
    M_AXIS_tready = 1'b1;
    options = 32'h0000_0003; index = 32'd60; store_data = 2'd2;
    tick(1'b0);
    store_data = 2'd0;
    wait_drain("mrst_drain");
    chk("mrst_len", got_q.size(), 6);
    if (got_q.size() != 0) chk("mrst_hdr_seq0", got_q[0], 32'h1000_0003);
    chk("mrst_seq_after", frame_seq, 1);

    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
